// File: rtl/cdc_fifo_write_arbiter_if.sv
// cdc_fifo_write_arbiter_if: requester and FIFO-facing bundle of the write-port arbiter
interface cdc_fifo_write_arbiter_if #(
  parameter int NUM_REQUESTERS = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST = 4
);
  localparam int IW = $clog2(NUM_REQUESTERS);
  localparam int CW = $clog2(MAX_BURST + 1);
  logic [NUM_REQUESTERS-1:0] req_valid;
  logic [NUM_REQUESTERS-1:0] req_last;
  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQUESTERS-1:0] req_ready;
  logic fifo_full;
  logic fifo_write_enable;
  logic [DATA_WIDTH-1:0] fifo_write_data;
  logic grant_valid;
  logic [IW-1:0] grant_id;
  logic [CW-1:0] burst_count;
  modport master (
    output req_valid, req_last, req_data, fifo_full,
    input req_ready, fifo_write_enable, fifo_write_data, grant_valid, grant_id, burst_count
  );
  modport slave (
    input req_valid, req_last, req_data, fifo_full,
    output req_ready, fifo_write_enable, fifo_write_data, grant_valid, grant_id, burst_count
  );
endinterface

// File: rtl/cdc_fifo_write_arbiter.sv
// cdc_fifo_write_arbiter: burst-atomic round-robin arbiter sharing the CDC FIFO write port
module cdc_fifo_write_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST = 4
) (
  input logic clock,
  input logic reset,
  cdc_fifo_write_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQUESTERS);
  localparam int IW1 = IW + 1;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BURST = 1'b1;
  localparam logic [IW:0] NR = IW1'(NUM_REQUESTERS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);
  localparam logic [NUM_REQUESTERS-1:0] ONE = 1;
  logic [0:0] state_q, state_d;
  logic [IW-1:0] grant_id_q, grant_id_d;
  logic [IW-1:0] last_grant_q, last_grant_d;
  logic [CW-1:0] burst_count_q, burst_count_d;
  logic [IW:0] cand;
  logic [IW-1:0] pick_id;
  logic pick_found, in_burst, accept, burst_end;
  // round-robin scan from just after the previous owner; lowest offset wins
  always_comb begin
    cand = '0;
    pick_found = 1'b0;
    pick_id = '0;
    for (int k = NUM_REQUESTERS; k >= 1; k--) begin
      cand = {1'b0, last_grant_q} + IW1'(k);
      cand = (cand >= NR) ? cand - NR : cand;
      pick_found = pick_found | bus.req_valid[cand[IW-1:0]];
      pick_id = bus.req_valid[cand[IW-1:0]] ? cand[IW-1:0] : pick_id;
    end
  end
  // owner handshake and FIFO write strobe, blocked in the same cycle by full
  always_comb begin
    in_burst = state_q == BURST;
    accept = in_burst & bus.req_valid[grant_id_q] & ~bus.fifo_full;
    burst_end = accept & (bus.req_last[grant_id_q] | (burst_count_q == LAST_BEAT));
    bus.req_ready = (in_burst & ~bus.fifo_full) ? ONE << grant_id_q : '0;
    bus.fifo_write_enable = accept;
    bus.fifo_write_data = bus.req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
    bus.grant_valid = in_burst;
    bus.grant_id = grant_id_q;
    bus.burst_count = burst_count_q;
  end
  // next state: arbitrate in IDLE, count accepted beats and release in BURST
  always_comb begin
    state_d = in_burst ? (burst_end ? IDLE : BURST) : (pick_found ? BURST : IDLE);
    grant_id_d = (!in_burst && pick_found) ? pick_id : grant_id_q;
    last_grant_d = burst_end ? grant_id_q : last_grant_q;
    burst_count_d = (burst_end || !in_burst) ? '0 : burst_count_q + CW'(accept);
  end
  // arbiter registers; the pointer resets so requester 0 is favoured first
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_id_q <= '0;
      last_grant_q <= IW'(NUM_REQUESTERS - 1);
      burst_count_q <= '0;
    end else begin
      state_q <= state_d;
      grant_id_q <= grant_id_d;
      last_grant_q <= last_grant_d;
      burst_count_q <= burst_count_d;
    end
  end
endmodule

// File: tb/tb_cdc_fifo_write_arbiter.sv
// tb_cdc_fifo_write_arbiter: scoreboard bench for the round-robin FIFO write arbiter
module tb_cdc_fifo_write_arbiter;
  localparam int N = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  logic [DW-1:0] sd [N][32];
  logic sl [N][32];
  int hd [N];
  int tl [N];
  logic [N-1:0] acc = '0;
  logic gv_prev = 1'b0;
  logic [DW-1:0] exp_d [$];
  int exp_g [$];

  cdc_fifo_write_arbiter_if #(.NUM_REQUESTERS(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) bus ();

  cdc_fifo_write_arbiter #(.NUM_REQUESTERS(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int id, input logic [DW-1:0] d, input logic l);
    sd[id][tl[id]] = d;
    sl[id][tl[id]] = l;
    tl[id]++;
  endtask

  task automatic wait_grant(input string tag);
    int n = 0;
    while (!bus.grant_valid && n < 50) begin
      @(negedge clock);
      n++;
    end
    check(tag, bus.grant_valid, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((exp_d.size() != 0 || bus.grant_valid) && n < 200) begin
      @(negedge clock);
      n++;
    end
    check(tag, exp_d.size(), 0);
    @(negedge clock);
  endtask

  // requester model: pop accepted beats and present the next one after each edge
  initial forever begin
    @(posedge clock);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) hd[i]++;
      bus.req_valid[i] = hd[i] < tl[i];
      bus.req_last[i] = (hd[i] < tl[i]) ? sl[i][hd[i]] : 1'b0;
      bus.req_data[i*DW +: DW] = (hd[i] < tl[i]) ? sd[i][hd[i]] : '0;
    end
  end

  // monitor: record handshakes, score FIFO writes and new grants
  initial forever begin
    @(negedge clock);
    acc = bus.req_valid & bus.req_ready;
    if (bus.fifo_write_enable) begin
      check("we_while_full", bus.fifo_full, 0);
      if (exp_d.size() == 0) check("wr_extra", exp_d.size(), 1);
      else check("wr_data", bus.fifo_write_data, exp_d.pop_front());
    end
    if (bus.grant_valid && !gv_prev) begin
      if (exp_g.size() == 0) check("grant_extra", exp_g.size(), 1);
      else check("grant_id", bus.grant_id, exp_g.pop_front());
    end
    gv_prev = bus.grant_valid;
  end

  initial begin
    bus.fifo_full = 1'b0;
    #8;
    check("rst_gv", bus.grant_valid, 0);
    check("rst_gid", bus.grant_id, 0);
    check("rst_bc", bus.burst_count, 0);
    check("rst_ready", bus.req_ready, 0);
    check("rst_we", bus.fifo_write_enable, 0);
    @(negedge clock);
    reset = 1'b0;
    // single requester, 3-beat burst
    push(2, 8'hA1, 0); push(2, 8'hA2, 0); push(2, 8'hA3, 1);
    exp_d.push_back(8'hA1); exp_d.push_back(8'hA2); exp_d.push_back(8'hA3);
    exp_g.push_back(2);
    wait_grant("t1_grant");
    check("t1_bc0", bus.burst_count, 0);
    @(negedge clock);
    check("t1_bc1", bus.burst_count, 1);
    @(negedge clock);
    check("t1_bc2", bus.burst_count, 2);
    check("t1_we_last", bus.fifo_write_enable, 1);
    @(negedge clock);
    check("t1_gv_end", bus.grant_valid, 0);
    check("t1_bc_end", bus.burst_count, 0);
    check("t1_gid_kept", bus.grant_id, 2);
    // round robin between requesters 0 and 1
    push(0, 8'h10, 1); push(0, 8'h11, 1);
    push(1, 8'h20, 1); push(1, 8'h21, 1);
    exp_d.push_back(8'h10); exp_d.push_back(8'h20); exp_d.push_back(8'h11); exp_d.push_back(8'h21);
    exp_g.push_back(0); exp_g.push_back(1); exp_g.push_back(0); exp_g.push_back(1);
    wait_idle("t2_done");
    // pointer wrap around requester 3
    push(3, 8'h30, 1);
    exp_d.push_back(8'h30); exp_g.push_back(3);
    wait_idle("t3a_done");
    push(0, 8'h40, 1); push(3, 8'h41, 1);
    exp_d.push_back(8'h40); exp_d.push_back(8'h41);
    exp_g.push_back(0); exp_g.push_back(3);
    wait_idle("t3b_done");
    // backpressure during burst cycles 2..4
    push(1, 8'h50, 0); push(1, 8'h51, 0); push(1, 8'h52, 0); push(1, 8'h53, 1);
    for (int i = 0; i < 4; i++) exp_d.push_back(8'h50 + 8'(i));
    exp_g.push_back(1);
    wait_grant("t4_grant");
    @(posedge clock);
    #2;
    bus.fifo_full = 1'b1;
    @(negedge clock);
    check("t4_ready_full", bus.req_ready[1], 0);
    check("t4_we_full", bus.fifo_write_enable, 0);
    check("t4_bc_c2", bus.burst_count, 1);
    @(negedge clock);
    check("t4_bc_c3", bus.burst_count, 1);
    @(negedge clock);
    check("t4_bc_c4", bus.burst_count, 1);
    check("t4_gv_held", bus.grant_valid, 1);
    @(posedge clock);
    #2;
    bus.fifo_full = 1'b0;
    wait_idle("t4_done");
    // MAX_BURST cutoff with requester 1 waiting
    for (int i = 0; i < 6; i++) push(0, 8'h60 + 8'(i), i == 5);
    push(1, 8'h70, 1);
    for (int i = 0; i < 4; i++) exp_d.push_back(8'h60 + 8'(i));
    exp_d.push_back(8'h70); exp_d.push_back(8'h64); exp_d.push_back(8'h65);
    exp_g.push_back(0); exp_g.push_back(1); exp_g.push_back(0);
    wait_grant("t5_grant");
    repeat (4) @(negedge clock);
    check("t5_gv_cut", bus.grant_valid, 0);
    check("t5_bc_cut", bus.burst_count, 0);
    wait_idle("t5_done");
    // asynchronous reset after the second beat
    for (int i = 0; i < 4; i++) push(1, 8'h80 + 8'(i), 0);
    exp_d.push_back(8'h80); exp_d.push_back(8'h81);
    exp_g.push_back(1);
    wait_grant("t6_grant");
    @(negedge clock);
    @(posedge clock);
    #3;
    check("t6_we_pre", bus.fifo_write_enable, 1);
    reset = 1'b1;
    #1;
    check("t6_gv_rst", bus.grant_valid, 0);
    check("t6_ready_rst", bus.req_ready, 0);
    check("t6_we_rst", bus.fifo_write_enable, 0);
    check("t6_bc_rst", bus.burst_count, 0);
    tl[1] = hd[1];
    @(negedge clock);
    push(0, 8'h90, 1); push(1, 8'h91, 1);
    exp_d.push_back(8'h90); exp_d.push_back(8'h91);
    exp_g.push_back(0); exp_g.push_back(1);
    @(posedge clock);
    #2;
    reset = 1'b0;
    wait_idle("t6_done");
    check("grants_left", exp_g.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
